// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared constants for the frame sequencer.
// State encoding, loop modes and default geometry.
package frame_seq_pkg;

  localparam int NUM_FRAMES_D = 30;
  localparam int FRAME_SIZE_D = 3328;
  localparam int ADDR_W_D     = 17;
  localparam int DIV_W_D      = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] LM_WRAP     = 2'd0;
  localparam logic [1:0] LM_ONCE     = 2'd1;
  localparam logic [1:0] LM_PINGPONG = 2'd2;

endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: MMIO controls in, frame status out.
// master = CPU/register side, slave = sequencer.
interface frame_sequencer_if import frame_seq_pkg::*; #(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DIV_W  = DIV_W_D
);
  logic              play;
  logic              step;
  logic              restart;
  logic              dir;
  logic [1:0]        loop_mode;
  logic [DIV_W-1:0]  period;
  logic              rev_sync;
  logic              sync_en;
  logic [7:0]        frame_idx;
  logic [ADDR_W-1:0] frame_offset;
  logic              frame_tick;
  logic              done;
  logic [1:0]        state;

  modport master (
    output play, step, restart, dir, loop_mode,
    output period, rev_sync, sync_en,
    input  frame_idx, frame_offset, frame_tick,
    input  done, state
  );

  modport slave (
    input  play, step, restart, dir, loop_mode,
    input  period, rev_sync, sync_en,
    output frame_idx, frame_offset, frame_tick,
    output done, state
  );
endinterface

// File: rtl/frame_rate_timer.sv
// frame_rate_timer: frame period counter with terminal count.
// Terminal when cnt >= period-1; period 0 never terminates.
module frame_rate_timer #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             term_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign term_o = (period_i != '0) &&
                  (cnt_q >= period_i - DIV_W'(1));

  // Clear beats hold; a terminal count restarts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (hold_i) cnt_d = cnt_q;
    else if (term_o) cnt_d = '0;
    else             cnt_d = cnt_q + DIV_W'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: animation frame index / texture base sequencer.
// Define FRAME_SEQ_REV_SYNC_EN to hold commits until rev_sync (ARMED).
module frame_sequencer import frame_seq_pkg::*; #(
  parameter int NUM_FRAMES = NUM_FRAMES_D,
  parameter int FRAME_SIZE = FRAME_SIZE_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int DIV_W      = DIV_W_D
) (
  input logic              clk,
  input logic              reset,
  frame_sequencer_if.slave bus
);
  localparam logic [7:0] LAST_IDX = 8'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] STEP_OFF = ADDR_W'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] LAST_OFF =
    ADDR_W'((NUM_FRAMES - 1) * FRAME_SIZE);
  localparam bit SINGLE = (NUM_FRAMES == 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        idx_q, idx_d, nidx;
  logic [ADDR_W-1:0] off_q, off_d, noff;
  logic              pp_q, pp_d, npp;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              run_en, term, fire, commit;
  logic              rev, at_end, once_end;

  assign run_en = (state_q == S_RUN) && bus.play && !bus.restart;
  assign fire   = run_en && term;

  frame_rate_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (!run_en),
    .clr_i    (bus.restart),
    .period_i (bus.period),
    .term_o   (term)
  );

  assign rev = (bus.loop_mode == LM_PINGPONG) ? (bus.dir ^ pp_q)
                                              : bus.dir;
  assign at_end   = rev ? (idx_q == 8'd0) : (idx_q == LAST_IDX);
  assign once_end = at_end && (bus.loop_mode == LM_ONCE);

  // Candidate next frame: step, wrap or bounce, offset tracked by +/-
  always_comb begin
    nidx = idx_q;
    noff = off_q;
    npp  = pp_q;
    unique case (1'b1)
      SINGLE: begin
      end
      (!SINGLE && at_end && bus.loop_mode == LM_PINGPONG): begin
        npp  = ~pp_q;
        nidx = rev ? idx_q + 8'd1 : idx_q - 8'd1;
        noff = rev ? off_q + STEP_OFF : off_q - STEP_OFF;
      end
      (!SINGLE && at_end && bus.loop_mode != LM_PINGPONG): begin
        nidx = rev ? LAST_IDX : 8'd0;
        noff = rev ? LAST_OFF : '0;
      end
      (!SINGLE && !at_end): begin
        nidx = rev ? idx_q - 8'd1 : idx_q + 8'd1;
        noff = rev ? off_q - STEP_OFF : off_q + STEP_OFF;
      end
    endcase
  end

  // Control FSM; restart outranks everything else
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    pp_d    = pp_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    commit  = 1'b0;
    if (bus.restart) begin
      idx_d   = bus.dir ? LAST_IDX : 8'd0;
      off_d   = bus.dir ? LAST_OFF : '0;
      pp_d    = 1'b0;
      done_d  = 1'b0;
      tick_d  = 1'b1;
      state_d = bus.play ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.step) commit = 1'b1;
          if (bus.play) state_d = S_RUN;
        end
        S_RUN: begin
          if (!bus.play) state_d = S_IDLE;
`ifdef FRAME_SEQ_REV_SYNC_EN
          else if (fire && bus.sync_en && !bus.rev_sync)
            state_d = S_ARMED;
`endif
          else if (fire) commit = 1'b1;
        end
`ifdef FRAME_SEQ_REV_SYNC_EN
        S_ARMED: begin
          if (!bus.play) state_d = S_IDLE;
          else if (bus.rev_sync || !bus.sync_en) begin
            commit  = 1'b1;
            state_d = S_RUN;
          end
        end
`endif
        S_DONE: begin
          if (!bus.play) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (commit) begin
        if (once_end) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d  = nidx;
          off_d  = noff;
          pp_d   = npp;
          tick_d = 1'b1;
        end
      end
    end
  end

`ifndef FRAME_SEQ_REV_SYNC_EN
  logic unused_sync;
  assign unused_sync = bus.sync_en ^ bus.rev_sync;
`endif

  // Sequencer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 8'd0;
      off_q   <= '0;
      pp_q    <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      pp_q    <= pp_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.frame_idx    = idx_q;
  assign bus.frame_offset = off_q;
  assign bus.frame_tick   = tick_q;
  assign bus.done         = done_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scenario tasks plus randomized run,
// each cycle checked against a frame-level reference model.
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  localparam int NF = 30;
  localparam int FS = 3328;

`ifdef FRAME_SEQ_REV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_sequencer_if bus ();

  frame_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model: 0 IDLE, 1 RUN, 2 ARMED, 3 DONE
  int     m_idx, m_st, m_pp;
  longint m_timer;
  bit     m_tick, m_done;

  task automatic model_reset();
    m_idx = 0; m_st = 0; m_pp = 0;
    m_timer = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit commit;
    int s, nxt;
    commit = 0;
    m_tick = 0;
    if (bus.restart) begin
      m_idx = bus.dir ? NF - 1 : 0;
      m_timer = 0; m_done = 0; m_pp = 0; m_tick = 1;
      m_st = bus.play ? 1 : 0;
      return;
    end
    case (m_st)
      0: begin
        if (bus.step) commit = 1;
        if (bus.play) m_st = 1;
      end
      1: begin
        if (!bus.play) m_st = 0;
        else if (bus.period != 0 && m_timer + 1 >= bus.period) begin
          m_timer = 0;
          if (SYNC_ON && bus.sync_en && !bus.rev_sync) m_st = 2;
          else commit = 1;
        end else m_timer++;
      end
      2: begin
        if (!bus.play) m_st = 0;
        else if (bus.rev_sync || !bus.sync_en) begin
          commit = 1; m_st = 1;
        end
      end
      default: if (!bus.play) m_st = 0;
    endcase
    if (commit) begin
      s = bus.dir ? -1 : 1;
      if (bus.loop_mode == 2 && m_pp != 0) s = -s;
      nxt = m_idx + s;
      if (nxt < 0 || nxt >= NF) begin
        if (bus.loop_mode == 1) begin
          m_st = 3; m_done = 1;
        end else if (NF == 1) m_tick = 1;
        else if (bus.loop_mode == 2) begin
          m_pp ^= 1; m_idx -= s; m_tick = 1;
        end else begin
          m_idx = (nxt + NF) % NF; m_tick = 1;
        end
      end else begin
        m_idx = nxt; m_tick = 1;
      end
    end
  endtask

  function automatic logic [28:0] exp_vec();
    return {8'(m_idx), 17'(m_idx * FS), m_tick, m_done, 2'(m_st)};
  endfunction

  function automatic logic [28:0] dut_vec();
    return {bus.frame_idx, bus.frame_offset, bus.frame_tick,
            bus.done, bus.state};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.play = 0; bus.step = 0; bus.restart = 0; bus.dir = 0;
    bus.loop_mode = LM_WRAP; bus.period = 0;
    bus.rev_sync = 0; bus.sync_en = 0;
  endtask

  task automatic do_restart(input bit play, input bit dir);
    bus.play = play; bus.dir = dir; bus.restart = 1;
    cyc();
    bus.restart = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 29'd0) begin
      errors++;
      $display("FAIL reset: got %h want 0", dut_vec());
    end
    reset = 1;
  endtask

  task automatic test_wrap();
    bus.loop_mode = LM_WRAP; bus.period = 4; bus.sync_en = 0;
    do_restart(1, 0);
    for (int c = 0; c < 125; c++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      checks++;
      if (bus.frame_tick !== (c % 4 == 3)) begin
        errors++;
        $display("FAIL wrap_tick c%0d: got %b", c, bus.frame_tick);
      end
      if (c == 115 || c == 119) begin
        checks++;
        if (bus.frame_offset !== (c == 115 ? 17'd96512 : 17'd0)) begin
          errors++;
          $display("FAIL wrap_off c%0d: got %0d", c, bus.frame_offset);
        end
      end
    end
  endtask

  task automatic test_pingpong();
    int seq[$];
    int offs[$];
    bus.loop_mode = LM_WRAP; bus.period = 2; bus.sync_en = 0;
    do_restart(0, 0);
    for (int i = 0; i < 28; i++) begin
      bus.step = 1; cyc(); bus.step = 0; cyc();
    end
    checks++;
    if (bus.frame_idx !== 8'd28 || bus.frame_offset !== 17'd93184) begin
      errors++;
      $display("FAIL pp_start: got %0d/%0d want 28/93184",
               bus.frame_idx, bus.frame_offset);
    end
    bus.loop_mode = LM_PINGPONG; bus.play = 1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pp c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (bus.frame_tick) begin
        seq.push_back(int'(bus.frame_idx));
        offs.push_back(int'(bus.frame_offset));
      end
    end
    checks++;
    if (seq.size() < 3 || seq[0] != 29 || seq[1] != 28 || seq[2] != 27 ||
        offs[0] != 96512 || offs[1] != 93184 || offs[2] != 89856) begin
      errors++;
      $display("FAIL pp_seq: got %p / %p want 29,28,27", seq, offs);
    end
    bus.play = 0;
  endtask

  task automatic test_once_rev();
    int tk = 0;
    bus.loop_mode = LM_ONCE; bus.period = 1; bus.sync_en = 0;
    do_restart(0, 1);
    checks++;
    if (bus.frame_idx !== 8'd29 || bus.frame_offset !== 17'd96512 ||
        bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL once_restart: got %0d/%0d/%b want 29/96512/1",
               bus.frame_idx, bus.frame_offset, bus.frame_tick);
    end
    bus.play = 1;
    for (int c = 0; c < 40; c++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL once c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (c >= 34 && bus.frame_tick) tk++;
    end
    checks++;
    if (bus.state !== S_DONE || bus.done !== 1'b1 ||
        bus.frame_idx !== 8'd0 || tk != 0) begin
      errors++;
      $display("FAIL once_done: got st%0d done%b idx%0d ticks%0d",
               bus.state, bus.done, bus.frame_idx, tk);
    end
    do_restart(1, 0);
    checks++;
    if (bus.done !== 1'b0 || bus.state !== S_RUN || bus.frame_idx !== 8'd0) begin
      errors++;
      $display("FAIL once_clear: got done%b st%0d idx%0d",
               bus.done, bus.state, bus.frame_idx);
    end
  endtask

  task automatic test_sync();
    bit hit = 0;
    bus.loop_mode = LM_WRAP; bus.period = 4; bus.sync_en = 1;
    do_restart(1, 0);
    for (int c = 0; c < 24; c++) begin
      bus.rev_sync = (c == 19);
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sync c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (c == 3 || c == 18 || c == 19) begin
        checks++;
        if ((c == 3 && bus.state !== (SYNC_ON ? S_ARMED : S_RUN)) ||
            (c == 18 && bus.frame_idx !== (SYNC_ON ? 8'd0 : 8'd4)) ||
            (c == 19 && bus.frame_idx !== (SYNC_ON ? 8'd1 : 8'd5))) begin
          errors++;
          $display("FAIL sync_pt c%0d: got st%0d idx%0d",
                   c, bus.state, bus.frame_idx);
        end
      end
    end
    for (int c = 0; c < 12 && !hit; c++) begin
      bus.rev_sync = (m_st == 1 && m_timer + 1 == longint'(bus.period));
      hit = bus.rev_sync;
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sync_co c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (!hit || bus.state !== S_RUN || bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL sync_coinc: got hit%b st%0d tick%b want RUN tick",
               hit, bus.state, bus.frame_tick);
    end
    bus.rev_sync = 0; bus.sync_en = 0; bus.play = 0;
  endtask

  task automatic test_step();
    bus.loop_mode = LM_WRAP; bus.period = 0; bus.sync_en = 0;
    do_restart(0, 0);
    repeat (3) begin
      bus.step = 1; cyc(); bus.step = 0; cyc();
    end
    checks++;
    if (bus.frame_idx !== 8'd3 || bus.frame_offset !== 17'd9984) begin
      errors++;
      $display("FAIL step3: got %0d/%0d want 3/9984",
               bus.frame_idx, bus.frame_offset);
    end
    bus.play = 1; cyc();
    bus.step = 1; cyc(); bus.step = 0; cyc();
    checks++;
    if (bus.frame_idx !== 8'd3 || bus.frame_tick !== 1'b0 ||
        bus.state !== S_RUN || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL step_run: got idx%0d tick%b st%0d",
               bus.frame_idx, bus.frame_tick, bus.state);
    end
    bus.play = 0; cyc();
    bus.restart = 1; bus.step = 1; cyc();
    bus.restart = 0; bus.step = 0;
    checks++;
    if (bus.frame_idx !== 8'd0 || bus.frame_tick !== 1'b1 ||
        dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL step_restart: got idx%0d tick%b want 0/1",
               bus.frame_idx, bus.frame_tick);
    end
  endtask

  task automatic test_reset_mid();
    bus.loop_mode = LM_WRAP; bus.period = 2; bus.sync_en = 0;
    do_restart(1, 0);
    for (int c = 0; c < 40 && m_idx != 7; c++) cyc();
    checks++;
    if (bus.frame_idx !== 8'd7 || bus.state !== S_RUN) begin
      errors++;
      $display("FAIL rmid_reach: got idx%0d st%0d want 7/RUN",
               bus.frame_idx, bus.state);
    end
    #2 reset = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 29'd0) begin
      errors++;
      $display("FAIL rmid_async: got %h want 0", dut_vec());
    end
    @(posedge clk);
    #1 reset = 1;
    do_restart(1, 0);
    checks++;
    if (bus.state !== S_RUN || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rmid_restart: got st%0d want RUN", bus.state);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.play    = ($urandom_range(0, 9) != 0);
      bus.step    = ($urandom_range(0, 7) == 0);
      bus.restart = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) bus.loop_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) bus.period = $urandom_range(0, 5);
      bus.sync_en  = ($urandom_range(0, 5) != 0);
      bus.rev_sync = ($urandom_range(0, 6) == 0);
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_pingpong();
    test_once_rev();
    test_sync();
    test_step();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
